// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

    // Default geometry: one 32-bit word per line, word-aligned addresses.
    localparam int ENTRIES_DEF = 128;
    localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
    localparam int TAG_W_DEF   = 30 - IDX_W_DEF;

    typedef logic [31:0] word_t;

    // Controller states: IDLE looks up, MISS waits for the requested word.
    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-stage and memory-controller signals of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic  if_req_i;
    word_t if_pc_i;
    logic  if_valid_o;
    word_t if_inst_o;
    word_t if_pc_o;
    logic  mem_fe_o;
    word_t mem_fpc_o;
    logic  mem_inst_ok_i;
    word_t mem_inst_i;
    word_t mem_inst_pc_i;
    logic  flush_i;

    // Cache side.
    modport slave (
        input  if_req_i, if_pc_i, mem_inst_ok_i, mem_inst_i, mem_inst_pc_i, flush_i,
        output if_valid_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o
    );

    // Fetch stage / memory controller side.
    modport master (
        output if_req_i, if_pc_i, mem_inst_ok_i, mem_inst_i, mem_inst_pc_i, flush_i,
        input  if_valid_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o
    );
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data line store: one synchronous write port, one combinational
// read port, and a one-cycle clear of every valid bit.
module icache_store
    import icache_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [TAG_W-1:0] wtag,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output word_t            rdata
);

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    word_t              data_mem [ENTRIES];

    // Valid bits: cleared together on reset or flush, set by each fill.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            valid_reg <= '0;
        end else if (we) begin
            valid_reg[waddr] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr]  <= wtag;
            data_mem[waddr] <= wdata;
        end
    end

    assign rvalid = valid_reg[raddr];
    assign rtag   = tag_mem[raddr];
    assign rdata  = data_mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single
// outstanding miss. Returned words are always cached, including prefetches.
module icache
    import icache_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    state_t state_reg, state_next;
    logic   if_valid_reg, if_valid_next;
    word_t  if_inst_reg, if_inst_next;
    word_t  if_pc_reg, if_pc_next;
    logic   mem_fe_reg, mem_fe_next;
    word_t  mem_fpc_reg, mem_fpc_next;

    logic [IDX_W-1:0] lk_idx, fl_idx;
    logic [TAG_W-1:0] lk_tag, fl_tag, rd_tag;
    logic             rd_valid;
    word_t            rd_data;
    logic             fill_same_idx, bypass, hit, ret_match, pc_stable;
    word_t            hit_word;
    logic             unused_low_bits;

    assign lk_idx = bus.if_pc_i[IDX_W+1:2];
    assign lk_tag = bus.if_pc_i[31:IDX_W+2];
    assign fl_idx = bus.mem_inst_pc_i[IDX_W+1:2];
    assign fl_tag = bus.mem_inst_pc_i[31:IDX_W+2];
    assign unused_low_bits = ^{bus.if_pc_i[1:0], bus.mem_inst_pc_i[1:0]};

    icache_store #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.flush_i),
        .we     (bus.mem_inst_ok_i && !bus.flush_i),
        .waddr  (fl_idx),
        .wtag   (fl_tag),
        .wdata  (bus.mem_inst_i),
        .raddr  (lk_idx),
        .rvalid (rd_valid),
        .rtag   (rd_tag),
        .rdata  (rd_data)
    );

    // A fill landing on the looked-up line this cycle overrides the stored
    // copy: exact address match is a bypass hit, any other tag is a miss.
    assign fill_same_idx = bus.mem_inst_ok_i && (fl_idx == lk_idx);
    assign bypass        = fill_same_idx && (fl_tag == lk_tag);
    assign hit           = fill_same_idx ? bypass : (rd_valid && rd_tag == lk_tag);
    assign hit_word      = fill_same_idx ? bus.mem_inst_i : rd_data;
    assign ret_match     = bus.mem_inst_ok_i && (bus.mem_inst_pc_i[31:2] == mem_fpc_reg[31:2]);
    assign pc_stable     = bus.if_req_i && (bus.if_pc_i[31:2] == mem_fpc_reg[31:2]);

    // Next-state and registered-output logic; a matching return wins over a
    // simultaneous redirect, flush wins over everything.
    always_comb begin
        state_next    = state_reg;
        if_valid_next = 1'b0;
        if_inst_next  = if_inst_reg;
        if_pc_next    = if_pc_reg;
        mem_fe_next   = mem_fe_reg;
        mem_fpc_next  = mem_fpc_reg;
        if (bus.flush_i) begin
            state_next  = IDLE;
            mem_fe_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mem_fe_next = 1'b0;
                    if (bus.if_req_i) begin
                        if (hit) begin
                            if_valid_next = 1'b1;
                            if_inst_next  = hit_word;
                            if_pc_next    = bus.if_pc_i;
                        end else begin
                            state_next   = MISS;
                            mem_fe_next  = 1'b1;
                            mem_fpc_next = bus.if_pc_i;
                        end
                    end
                end
                MISS: begin
                    if (ret_match) begin
                        if_valid_next = 1'b1;
                        if_inst_next  = bus.mem_inst_i;
                        if_pc_next    = bus.mem_inst_pc_i;
                        state_next    = IDLE;
                        mem_fe_next   = 1'b0;
                    end else if (!pc_stable) begin
                        state_next  = IDLE;
                        mem_fe_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            if_valid_reg <= 1'b0;
            if_inst_reg  <= '0;
            if_pc_reg    <= '0;
            mem_fe_reg   <= 1'b0;
            mem_fpc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            if_valid_reg <= if_valid_next;
            if_inst_reg  <= if_inst_next;
            if_pc_reg    <= if_pc_next;
            mem_fe_reg   <= mem_fe_next;
            mem_fpc_reg  <= mem_fpc_next;
        end
    end

    assign bus.if_valid_o = if_valid_reg;
    assign bus.if_inst_o  = if_inst_reg;
    assign bus.if_pc_o    = if_pc_reg;
    assign bus.mem_fe_o   = mem_fe_reg;
    assign bus.mem_fpc_o  = mem_fpc_reg;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed scenarios followed by random fetch
// traffic, checked against an address-level cache model.
module tb_icache;

    localparam int ENTRIES = 128;

    typedef struct {
        int          cyc;
        logic [31:0] inst;
        logic [31:0] pc;
    } dlv_t;

    typedef struct {
        bit          fe;
        logic [31:0] fpc;
        bit          zero_chk;
    } st_t;

    typedef struct {
        int          due;
        logic [31:0] pc;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    icache_if bus();

    icache #(.ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   running = 1'b0;
    bit   auto_mem = 1'b0;
    int   drv_cyc = 0;
    int   mon_cyc = 0;
    dlv_t dq[$];
    st_t  sq[$];
    ret_t pend[$];

    // Reference model: lines hold the full word address they cache.
    bit          mv  [ENTRIES];
    logic [29:0] mwa [ENTRIES];
    logic [31:0] md  [ENTRIES];
    bit          m_wait = 1'b0;
    logic [31:0] m_want = '0;
    logic [31:0] m_fpc  = '0;

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 2);
    endfunction

    // One clock of stimulus plus the model's expected response.
    task automatic step(input bit req, input logic [31:0] pc, input bit ok,
                        input logic [31:0] rpc, input logic [31:0] rw,
                        input bit fl, input bit rn);
        int  k;
        bit  zc;
        @(negedge clk);
        bus.if_req_i      = req;
        bus.if_pc_i       = pc;
        bus.mem_inst_ok_i = ok;
        bus.mem_inst_pc_i = rpc;
        bus.mem_inst_i    = rw;
        bus.flush_i       = fl;
        rst               = rn;
        running           = 1'b1;
        drv_cyc++;
        zc = 1'b0;
        if (!rn) begin
            for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
            m_wait = 1'b0;
            m_fpc  = '0;
            zc     = 1'b1;
        end else if (fl) begin
            for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
            m_wait = 1'b0;
        end else begin
            if (ok) begin
                k = idx_of(rpc);
                mv[k] = 1'b1; mwa[k] = rpc[31:2]; md[k] = rw;
            end
            if (!m_wait) begin
                if (req) begin
                    k = idx_of(pc);
                    if (mv[k] && mwa[k] == pc[31:2]) begin
                        dq.push_back('{drv_cyc, md[k], pc});
                    end else begin
                        m_wait = 1'b1; m_want = pc; m_fpc = pc;
                        if (auto_mem) pend.push_back('{drv_cyc + int'($urandom_range(2, 6)), pc});
                    end
                end
            end else if (ok && rpc == m_want) begin
                dq.push_back('{drv_cyc, rw, rpc});
                m_wait = 1'b0;
            end else if (!req || pc != m_want) begin
                m_wait = 1'b0;
            end
        end
        sq.push_back('{m_wait, m_fpc, zc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: one pop of the per-cycle expectation, deliveries matched by cycle.
    initial begin
        st_t  st;
        dlv_t d;
        bit   exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (!running) continue;
            mon_cyc++;
            if (sq.size() == 0) begin
                bad++; total++;
                $display("FAIL sq_empty cycle=%0d", mon_cyc);
                continue;
            end
            st = sq.pop_front();
            total++;
            if (bus.mem_fe_o !== st.fe) begin
                bad++;
                $display("FAIL mem_fe cycle=%0d got=%0b exp=%0b", mon_cyc, bus.mem_fe_o, st.fe);
            end
            if (st.fe || st.zero_chk) begin
                total++;
                if (bus.mem_fpc_o !== st.fpc) begin
                    bad++;
                    $display("FAIL mem_fpc cycle=%0d got=%h exp=%h", mon_cyc, bus.mem_fpc_o, st.fpc);
                end
            end
            if (st.zero_chk) begin
                total++;
                if (bus.if_inst_o !== 32'h0 || bus.if_pc_o !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_out cycle=%0d got inst=%h pc=%h exp 0", mon_cyc, bus.if_inst_o, bus.if_pc_o);
                end
            end
            exp_v = (dq.size() > 0) && (dq[0].cyc == mon_cyc);
            total++;
            if (bus.if_valid_o !== exp_v) begin
                bad++;
                $display("FAIL if_valid cycle=%0d got=%0b exp=%0b", mon_cyc, bus.if_valid_o, exp_v);
            end
            if (exp_v) begin
                d = dq.pop_front();
                if (bus.if_valid_o === 1'b1) begin
                    total++;
                    if (bus.if_inst_o !== d.inst || bus.if_pc_o !== d.pc) begin
                        bad++;
                        $display("FAIL deliver cycle=%0d got inst=%h pc=%h exp inst=%h pc=%h",
                                 mon_cyc, bus.if_inst_o, bus.if_pc_o, d.inst, d.pc);
                    end else begin
                        $display("deliver cycle=%0d pc=%h inst=%h", mon_cyc, d.pc, d.inst);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ret_t r;
        bus.if_req_i = 0; bus.if_pc_i = 0; bus.mem_inst_ok_i = 0;
        bus.mem_inst_pc_i = 0; bus.mem_inst_i = 0; bus.flush_i = 0;

        // Reset, then cold miss on 0x10 returning 0x00A00093.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h10, 0, 0, 0, 0, 1);
        step(1, 32'h10, 0, 0, 0, 0, 1);
        step(1, 32'h10, 0, 0, 0, 0, 1);
        step(1, 32'h10, 1, 32'h10, 32'h00A0_0093, 0, 1);
        idle(1);
        // Re-request hits; back-to-back hits.
        step(1, 32'h10, 0, 0, 0, 0, 1);
        step(1, 32'h10, 0, 0, 0, 0, 1);
        idle(1);
        // Conflict: 0x210 shares the index of 0x10.
        step(1, 32'h210, 0, 0, 0, 0, 1);
        step(1, 32'h210, 1, 32'h210, mem_word(32'h210), 0, 1);
        step(1, 32'h10, 0, 0, 0, 0, 1);
        step(1, 32'h10, 1, 32'h10, mem_word(32'h10), 0, 1);
        idle(1);
        // Redirect 0x40 -> 0x80, late return of 0x40 only fills.
        step(1, 32'h40, 0, 0, 0, 0, 1);
        step(1, 32'h80, 0, 0, 0, 0, 1);
        step(1, 32'h80, 0, 0, 0, 0, 1);
        step(1, 32'h80, 1, 32'h40, mem_word(32'h40), 0, 1);
        step(1, 32'h80, 1, 32'h80, mem_word(32'h80), 0, 1);
        step(1, 32'h40, 0, 0, 0, 0, 1);
        idle(1);
        // Prefetch bypass and same-index different-tag fill.
        step(1, 32'h44, 1, 32'h44, 32'h1234_5678, 0, 1);
        step(1, 32'h80, 1, 32'h280, mem_word(32'h280), 0, 1);
        step(0, 0, 1, 32'h80, mem_word(32'h80), 0, 1);
        // Fill 0x14, flush, both 0x10 and 0x14 miss; reset mid-miss.
        step(1, 32'h14, 0, 0, 0, 0, 1);
        step(1, 32'h14, 1, 32'h14, mem_word(32'h14), 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 32'h10, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h14, 0, 0, 0, 0, 1);
        step(1, 32'h14, 0, 0, 0, 0, 0);
        idle(2);

        // Random fetch traffic with an auto-responding memory.
        auto_mem = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bit          req, ok, fl, rn;
            logic [31:0] pc, rpc, rw;
            if (m_wait && $urandom_range(0, 99) < 85) begin
                req = 1; pc = m_want;
            end else begin
                req = ($urandom_range(0, 99) < 80); pc = rand_pc();
            end
            ok = 0; rpc = 0; rw = 0;
            if (pend.size() > 0 && pend[0].due <= drv_cyc + 1) begin
                r = pend.pop_front();
                ok = 1; rpc = r.pc;
            end else if ($urandom_range(0, 99) < 8) begin
                ok = 1; rpc = rand_pc();
            end
            if (ok) rw = mem_word(rpc) ^ $urandom_range(0, 3);
            fl = ($urandom_range(0, 199) == 0);
            rn = !($urandom_range(0, 299) == 0);
            step(req, pc, ok, rpc, rw, fl, rn);
        end
        idle(2);

        @(posedge clk);
        #2;
        running = 1'b0;
        total++;
        if (dq.size() != 0 || sq.size() != 0) begin
            bad++;
            $display("FAIL leftover deliveries=%0d states=%0d exp 0", dq.size(), sq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
